// File: rtl/spm_pkg.sv
// Shared types and constants for the serial-parallel multiplier controller.
// No logic, so no latency.
// No handshake, so no backpressure.
package spm_pkg;

    // Default operand width of the multiplier datapath.
    localparam int SPM_SIZE = 32;

    // Controller sequencing: accept, stream operand bits, collect the last product bit, present.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } spm_state_t;

    // Width of a counter that must hold every value from 0 to 2*sz inclusive.
    function automatic int spm_cnt_width(input int sz);
        return $clog2(2 * sz + 1);
    endfunction

endpackage

// File: rtl/spm_shift.sv
// Right shift register with parallel load. Serves as the operand serializer and the product deserializer.
// Latency: one clock edge per load or shift. Load takes priority over shift.
// No backpressure: the register holds its value whenever neither enable is set.
module spm_shift
    import spm_pkg::*;
#(
    parameter int W = 2 * SPM_SIZE
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         shift,
    input  logic         shift_in,
    output logic [W-1:0] q
);

    // Load wins over shift. A shift moves every bit one place toward bit 0, and the MSB takes shift_in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (shift) begin
            q <= {shift_in, q[W-1:1]};
        end
    end

endmodule

// File: rtl/spm_ctrl.sv
// Sequences one signed multiply through an external serial-parallel multiplier (spm) and collects the product.
// Latency: out_valid rises 2*size+1 cycles after the accept edge.
// Backpressure: in_ready is high only in IDLE, and the product holds in DONE until out_ready. Optional macro SPM_CTRL_PERF_EN adds ops_cnt.
module spm_ctrl
    import spm_pkg::*;
#(
    parameter int size = SPM_SIZE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [size-1:0]   mc,
    input  logic [size-1:0]   mp,
    output logic [size-1:0]   spm_x,
    output logic              spm_y,
    output logic              spm_rst,
    input  logic              spm_p,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*size-1:0] prod
`ifdef SPM_CTRL_PERF_EN
    ,
    output logic [15:0]       ops_cnt
`endif
);

    localparam int PW = 2 * size;
    localparam int CW = spm_cnt_width(size);
    localparam logic [CW-1:0] CNT_LAST = CW'(PW - 1);

    spm_state_t     state;
    spm_state_t     state_nxt;
    logic [CW-1:0]  cnt;
    logic           accept;
    logic           mp_shift;
    logic           prod_shift;
    logic [PW-1:0]  mp_ext;
    logic [PW-1:0]  mp_sr;
    logic           unused_mp_hi;

    // The multiplier is signed, so it is sign-extended to the full product width before serializing.
    assign mp_ext = {{size{mp[size-1]}}, mp};
    assign accept = in_valid & in_ready;

    // Only bit 0 of the serializer leaves the block. The upper bits matter only inside the shifter.
    assign unused_mp_hi = |mp_sr[PW-1:1];

    // Hold the FSM state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Compute the next state, the handshake outputs and the shift enables from the current state.
    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        mp_shift   = 1'b0;
        prod_shift = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                mp_shift = 1'b1;
                // The spm output is registered, so nothing useful appears before the second RUN cycle.
                prod_shift = (cnt != '0);
                if (cnt == CNT_LAST) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Collect the last product bit, which lags the last operand bit by one cycle.
                prod_shift = 1'b1;
                state_nxt  = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Count RUN cycles. The counter restarts at each accept and ends at 2*size in DRAIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= '0;
        end else if (state == RUN) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Capture the multiplicand at accept. It stays stable on spm_x for the whole operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spm_x <= '0;
        end else if (accept) begin
            spm_x <= mc;
        end
    end

    // spm_rst is registered so the multiplier's clear never glitches. It is high exactly while the FSM sits in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spm_rst <= 1'b1;
        end else begin
            spm_rst <= (state_nxt == IDLE);
        end
    end

    // Gate the serial operand bit so the multiplier sees zeros outside RUN.
    assign spm_y = (state == RUN) & mp_sr[0];

    spm_shift #(.W(PW)) u_mp_ser (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (mp_ext),
        .shift    (mp_shift),
        .shift_in (1'b0),
        .q        (mp_sr)
    );

    // Product bits arrive LSB first at the MSB. After 2*size shifts bit 0 has reached the bottom.
    // prod is never cleared at accept, so the last product stays visible until new bits overwrite it.
    spm_shift #(.W(PW)) u_prod_des (
        .clk      (clk),
        .rst      (rst),
        .load     (1'b0),
        .load_val ({PW{1'b0}}),
        .shift    (prod_shift),
        .shift_in (spm_p),
        .q        (prod)
    );

`ifdef SPM_CTRL_PERF_EN
    // Count completed output handshakes. The counter wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ops_cnt <= 16'd0;
        end else if (out_valid & out_ready) begin
            ops_cnt <= ops_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_spm_ctrl.sv
// Directed bench for spm_ctrl with a behavioural serial-parallel multiplier attached.
// Each product is a hand-computed constant. Latency, serial operand bits, stall and reset behaviour are checked.
// The summary line reports passed and total comparisons.
module tb_spm_ctrl;

    localparam int SZ = 32;
    localparam int PW = 2 * SZ;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [SZ-1:0] mc;
    logic [SZ-1:0] mp;
    logic [SZ-1:0] spm_x;
    logic          spm_y;
    logic          spm_rst;
    logic          spm_p;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] prod;
`ifdef SPM_CTRL_PERF_EN
    logic [15:0]   ops_cnt;
`endif

    int passes = 0;
    int fails  = 0;
    int total  = 0;

    spm_ctrl #(.size(SZ)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mc        (mc),
        .mp        (mp),
        .spm_x     (spm_x),
        .spm_y     (spm_y),
        .spm_rst   (spm_rst),
        .spm_p     (spm_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prod      (prod)
`ifdef SPM_CTRL_PERF_EN
        ,
        .ops_cnt   (ops_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Serial-parallel multiplier. Each cycle it adds x to the running sum when y is set, emits the sum LSB one cycle later, and halves the sum.
    logic                 spm_clr;
    logic signed [PW+1:0] acc;
    logic signed [PW+1:0] sum;
    assign spm_clr = rst | spm_rst;

    always @(posedge clk or posedge spm_clr) begin
        if (spm_clr) begin
            acc   <= '0;
            spm_p <= 1'b0;
        end else begin
            sum = acc + (spm_y ? {{(PW + 2 - SZ){spm_x[SZ-1]}}, spm_x} : {(PW + 2){1'b0}});
            spm_p <= sum[0];
            acc   <= sum >>> 1;
        end
    end

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one operation from accept through the output handshake.
    // Optionally stalls in DONE for `hold` cycles and pulses in_valid with junk operands during RUN.
    task automatic run_op(input logic [SZ-1:0] a, input logic [SZ-1:0] b, input logic [PW-1:0] exp,
                          input int hold, input bit noise, input string tag);
        logic [PW-1:0] ext;
        logic [PW-1:0] ybits;
        logic          drain_y;
        int            edges;
        bit            ok;
        ext     = {{SZ{b[SZ-1]}}, b};
        ybits   = '0;
        drain_y = 1'b0;
        @(negedge clk);
        chk({tag, ":in_ready_idle"}, PW'(in_ready), PW'(1));
        mc       = a;
        mp       = b;
        in_valid = 1'b1;
        @(posedge clk);
        edges = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (c == 0) begin
                in_valid = 1'b0;
                chk({tag, ":spm_rst_run"}, PW'(spm_rst), PW'(0));
            end
            if (out_valid) break;
            if (c < PW) ybits[c] = spm_y;
            else drain_y = spm_y;
            if (noise) begin
                in_valid = ((c % 9) == 4) && (c < 60);
                mc       = ~a;
                mp       = ~b;
                if (c == 4) chk({tag, ":in_ready_run"}, PW'(in_ready), PW'(0));
            end
            @(posedge clk);
            edges++;
        end
        in_valid = 1'b0;
        chk({tag, ":latency"},   PW'(edges),     PW'(65));
        chk({tag, ":out_valid"}, PW'(out_valid), PW'(1));
        chk({tag, ":prod"},      prod,           exp);
        chk({tag, ":spm_y_seq"}, ybits,          ext);
        chk({tag, ":spm_y_drn"}, PW'(drain_y),   PW'(0));
        chk({tag, ":spm_x"},     PW'(spm_x),     PW'(a));
        if (hold > 0) begin
            ok = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(posedge clk);
                @(negedge clk);
                if (out_valid !== 1'b1 || prod !== exp || in_ready !== 1'b0 ||
                    spm_y !== 1'b0 || spm_rst !== 1'b0) ok = 1'b0;
            end
            chk({tag, ":hold_stable"}, PW'(ok), PW'(1));
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ":ov_after_hs"},  PW'(out_valid), PW'(0));
        chk({tag, ":rdy_after_hs"}, PW'(in_ready),  PW'(1));
        chk({tag, ":prod_kept"},    prod,           exp);
        chk({tag, ":spm_rst_idle"}, PW'(spm_rst),   PW'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mc        = '0;
        mp        = '0;
        #2;
        chk("rst:in_ready",  PW'(in_ready),  PW'(1));
        chk("rst:out_valid", PW'(out_valid), PW'(0));
        chk("rst:prod",      prod,           PW'(0));
        chk("rst:spm_x",     PW'(spm_x),     PW'(0));
        chk("rst:spm_y",     PW'(spm_y),     PW'(0));
        chk("rst:spm_rst",   PW'(spm_rst),   PW'(1));
`ifdef SPM_CTRL_PERF_EN
        chk("rst:ops_cnt",   PW'(ops_cnt),   PW'(0));
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op(32'd3,          32'd5,          64'h000000000000000F, 10, 1'b1, "op3x5");
        run_op(32'hFFFFFFFE,   32'd7,          64'hFFFFFFFFFFFFFFF2, 0,  1'b0, "opm2x7");
        run_op(32'h80000000,   32'h80000000,   64'h4000000000000000, 0,  1'b0, "opminsq");
        run_op(32'h7FFFFFFF,   32'hFFFFFFFF,   64'hFFFFFFFF80000001, 0,  1'b0, "opmaxm1");

        // Abandon an operation partway through RUN with an asynchronous reset.
        @(negedge clk);
        mc       = 32'd5;
        mp       = 32'd9;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst:in_ready",  PW'(in_ready),  PW'(1));
        chk("midrst:spm_rst",   PW'(spm_rst),   PW'(1));
        chk("midrst:out_valid", PW'(out_valid), PW'(0));
        chk("midrst:spm_y",     PW'(spm_y),     PW'(0));
        chk("midrst:prod",      prod,           PW'(0));
`ifdef SPM_CTRL_PERF_EN
        chk("midrst:ops_cnt",   PW'(ops_cnt),   PW'(0));
`endif
        @(negedge clk);
        rst = 1'b0;

        run_op(32'd6,          32'hFFFFFFFD,   64'hFFFFFFFFFFFFFFEE, 0,  1'b0, "op6xm3");
        run_op(32'd3,          32'd5,          64'h000000000000000F, 0,  1'b0, "op3x5b");
        run_op(32'hFFFFFFFF,   32'hFFFFFFFF,   64'h0000000000000001, 0,  1'b0, "opm1xm1");
`ifdef SPM_CTRL_PERF_EN
        chk("perf:ops_cnt", PW'(ops_cnt), PW'(3));
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
